dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of the number of 32-bit words stored (256 words).
REQ-002 The block SHALL have parameter LATENCY, default 2, legal range 1..15, meaning the number of cycles from request acceptance to the done pulse.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit, synchronous active-low reset.
REQ-005 The block SHALL have port req, input, 1 bit, the datapath memory request valid.
REQ-006 The block SHALL have port we, input, 1 bit, where 1 means word write and 0 means word read.
REQ-007 The block SHALL have port addr, input, 32 bits, the byte address (the datapath ALU result).
REQ-008 The block SHALL have port wdata, input, 32 bits, the store data (the datapath register rd2).
REQ-009 The block SHALL have port rdata, output, 32 bits, the read data returned to the datapath.
REQ-010 The block SHALL have port ready, output, 1 bit, meaning the block can accept a request this cycle.
REQ-011 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-012 The block SHALL have port err, output, 1 bit, the misaligned-access flag, valid with done.

Function
REQ-013 The block SHALL implement FSM states IDLE, BUSY and DONE.
REQ-014 ready SHALL be 1 only in IDLE; a request is accepted when req=1 and ready=1 at a rising edge.
REQ-015 On accept, the block SHALL latch addr, we and wdata, and load the wait counter with LATENCY-1.
REQ-016 On accept, the FSM SHALL go to DONE directly if LATENCY=1; otherwise it SHALL go to BUSY.
REQ-017 In BUSY, the counter SHALL decrement each cycle; when it reaches 1, the FSM SHALL go to DONE on the next edge.
REQ-018 done SHALL be 1 for exactly the one cycle spent in DONE, so an accept at edge T gives done high in cycle T+LATENCY; DONE SHALL always return to IDLE.
REQ-019 The word index SHALL be the latched addr[DEPTH_LOG2+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 4*2^DEPTH_LOG2.
REQ-020 A write SHALL commit mem[index]=wdata on the edge entering DONE; rdata SHALL be unchanged by a write.
REQ-021 A read SHALL load rdata from mem[index] on the edge entering DONE; rdata SHALL hold that value until the next completed read.
REQ-022 A read SHALL return the value of any write that completed earlier (read-after-write coherent).
REQ-023 req while ready=0 SHALL be ignored, with no queuing; the requester holds req until accepted.
REQ-024 Maximum throughput SHALL be one transaction per LATENCY+1 cycles.
REQ-025 Input changes after accept SHALL NOT affect the in-flight transaction.

Reset
REQ-026 While rst=0 at an edge, the block SHALL set state=IDLE, counter=0, rdata=0, done=0 and err=0.
REQ-027 Reset mid-transaction SHALL abort it with no memory write committed and no done pulse.
REQ-028 Memory contents SHALL NOT be cleared by reset.
REQ-029 The first accept SHALL be possible on the first edge with rst=1.

Configuration
REQ-030 Macro DMEM_ALIGN_CHECK_EN SHALL control alignment checking.
REQ-031 With DMEM_ALIGN_CHECK_EN defined, a latched addr[1:0]!=0 SHALL suppress the memory write and rdata update, and SHALL set err=1 in the DONE cycle with normal timing; err SHALL be 0 otherwise.
REQ-032 Without DMEM_ALIGN_CHECK_EN, addr[1:0] SHALL be ignored and err SHALL be tied to 0.

Verification
REQ-033 Reset then idle: rst=0 for 2 cycles, then rst=1 -> ready=1, done=0, rdata=0x00000000, err=0.
REQ-034 LATENCY=2: write addr=0x10, wdata=0xDEADBEEF accepted at T -> done=1 only in T+2; then read 0x10 -> rdata=0xDEADBEEF in its done cycle.
REQ-035 Wrap, DEPTH_LOG2=8: write 0x00000404 with 0x12345678, read 0x00000004 -> rdata=0x12345678.
REQ-036 Reset mid-op: write 0x20 with 0xAAAAAAAA accepted, rst=0 one cycle later -> no done; a later read of 0x20 returns the prior contents.
REQ-037 Back-to-back: req held high with LATENCY=2 -> accepts spaced exactly 3 cycles apart; ready=0 in BUSY/DONE.
REQ-038 DMEM_ALIGN_CHECK_EN defined: write 0x22 with 0x55555555 -> done with err=1; a read of 0x20 shows the old data and err=0.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: fixed-latency word read/write with a one-cycle done pulse.
// Optional misaligned-access detection is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        done,
  output logic        err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state, state_next;
  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] idx_q, idx_eff;
  logic                  we_q, we_eff;
  logic [31:0]           wdata_q, wdata_eff;
  logic                  mis_eff;
  logic                  accept, enter_done;
  logic [31:0]           mem [DEPTH];

  assign ready  = (state == IDLE);
  assign done   = (state == DONE);
  assign accept = req && ready;

  // With LATENCY=1 the DONE-entering edge is the accept edge itself, so the live inputs are used
  assign idx_eff   = (state == IDLE) ? addr[DEPTH_LOG2+1:2] : idx_q;
  assign we_eff    = (state == IDLE) ? we    : we_q;
  assign wdata_eff = (state == IDLE) ? wdata : wdata_q;

`ifdef DMEM_ALIGN_CHECK_EN
  logic mis_q;
  logic unused_addr_bits;

  assign mis_eff          = (state == IDLE) ? (addr[1:0] != 2'b00) : mis_q;
  assign err              = done && mis_q;
  assign unused_addr_bits = ^addr[31:DEPTH_LOG2+2];

  always_ff @(posedge clk) begin
    if (accept) mis_q <= (addr[1:0] != 2'b00);
  end
`else
  logic unused_addr_bits;

  assign mis_eff          = 1'b0;
  assign err              = 1'b0;
  assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) state_next = DONE;
          else              state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd1) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign enter_done = (state_next == DONE) && (state != DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rdata <= 32'd0;
    end else begin
      state <= state_next;
      if (accept) begin
        cnt     <= 4'(LATENCY - 1);
        idx_q   <= addr[DEPTH_LOG2+1:2];
        we_q    <= we;
        wdata_q <= wdata;
      end else if (state == BUSY) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_done && !we_eff && !mis_eff) rdata <= mem[idx_eff];
    end
  end

  // Memory is deliberately not reset; a reset edge also blocks any pending commit
  always_ff @(posedge clk) begin
    if (rst && enter_done && we_eff && !mis_eff) mem[idx_eff] <= wdata_eff;
  end

endmodule
